// File: rtl/prbs_chk.sv
// Receive-side PRBS checker.
// Self-synchronises to an incoming PRBS stream (HUNT), then free-runs its own
// LFSR (LOCKED) and reports per-word bit errors plus saturating error/word
// counters for BER measurement. All logic runs on the RX user clock.
module prbs_chk #(
    parameter int                size       = 32,
    parameter int                length     = 7,
    parameter logic [0:length-1] primpoly   = 7'b0000011,
    parameter int                LOCK_CNT   = 4,
    parameter int                UNLOCK_CNT = 4,
    parameter int                CNT_W      = 32
) (
    input  logic                       gtwiz_userclk_rx_usrclk2_in,
    input  logic                       gtwiz_reset_all_in,
    input  logic [size-1:0]            data_in,
    input  logic                       data_valid_in,
    input  logic                       clear_cnt_in,
    output logic                       locked_out,
    output logic                       err_out,
    output logic [$clog2(size+1)-1:0]  err_bits_out,
    output logic [CNT_W-1:0]           err_cnt_out,
    output logic [CNT_W-1:0]           word_cnt_out
);

    localparam int ERR_W  = $clog2(size + 1);
    localparam int CRUN_W = $clog2(LOCK_CNT + 1);
    localparam int BRUN_W = $clog2(UNLOCK_CNT + 1);
    // Wide enough that adding a full word's error count cannot wrap even when
    // the counter is narrower than the per-word error count.
    localparam int SUM_W  = ((CNT_W > ERR_W) ? CNT_W : ERR_W) + 1;

    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Next `size` sequence bits following a history of `length` bits.
    // seed[k-1] holds x[n-k], i.e. seed[0] is the most recent bit. The first
    // generated bit lands in the word MSB (earliest in time).
    function automatic logic [size-1:0] predict(input logic [length-1:0] seed);
        logic [length-1:0] st;
        logic              fb;
        logic [size-1:0]   word;
        st   = seed;
        word = '0;
        for (int i = 0; i < size; i++) begin
            fb = 1'b0;
            for (int k = 1; k <= length; k++) begin
                fb = fb ^ (primpoly[k-1] & st[k-1]);
            end
            word[size-1-i] = fb;
            st             = {st[length-2:0], fb};
        end
        return word;
    endfunction

    function automatic logic [ERR_W-1:0] popcount(input logic [size-1:0] v);
        logic [ERR_W-1:0] n;
        n = '0;
        for (int i = 0; i < size; i++) begin
            n = n + ERR_W'(v[i]);
        end
        return n;
    endfunction

    state_t              state_q,     state_d;
    logic [length-1:0]   seed_q,      seed_d;
    logic [length-1:0]   lfsr_q,      lfsr_d;
    logic [CRUN_W-1:0]   clean_run_q, clean_run_d;
    logic [BRUN_W-1:0]   bad_run_q,   bad_run_d;
    logic                err_q,       err_d;
    logic [ERR_W-1:0]    err_bits_q,  err_bits_d;
    logic [CNT_W-1:0]    err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0]    word_cnt_q,  word_cnt_d;

    logic [length-1:0]   pred_seed;
    logic [size-1:0]     pred_word;
    logic [ERR_W-1:0]    word_err_bits;
    logic                word_clean;
    logic                seed_ok;
    logic [SUM_W-1:0]    err_sum;

    // One shared unrolled predictor: seeded from received data while hunting,
    // from the free-running LFSR once locked so a bit error counts only once.
    assign pred_seed     = (state_q == LOCKED) ? lfsr_q : seed_q;
    assign pred_word     = predict(pred_seed);
    assign word_err_bits = popcount(data_in ^ pred_word);
    assign word_clean    = (data_in == pred_word);
    // An all-zero history also covers the first word after reset, whose seed
    // register still holds its reset value of zero.
    assign seed_ok       = |seed_q;
    assign err_sum       = SUM_W'(err_cnt_q) + SUM_W'(word_err_bits);

    // Next-state logic: lock FSM, run counters, error reporting and counters.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d     = state_q;
        seed_d      = seed_q;
        lfsr_d      = lfsr_q;
        clean_run_d = clean_run_q;
        bad_run_d   = bad_run_q;
        err_d       = 1'b0;
        err_bits_d  = err_bits_q;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;

        if (data_valid_in) begin
            // The received history is always tracked so HUNT can resume at once.
            seed_d = data_in[length-1:0];

            case (state_q)
                HUNT: begin
                    err_bits_d = '0;
                    if (word_clean && seed_ok) begin
                        if (clean_run_q == CRUN_W'(LOCK_CNT - 1)) begin
                            state_d     = LOCKED;
                            lfsr_d      = data_in[length-1:0];
                            clean_run_d = '0;
                            bad_run_d   = '0;
                        end else begin
                            clean_run_d = clean_run_q + 1'b1;
                        end
                    end else begin
                        clean_run_d = '0;
                    end
                end

                LOCKED: begin
                    // After a full word the LFSR history is the predicted word's tail.
                    lfsr_d     = pred_word[length-1:0];
                    err_bits_d = word_err_bits;
                    err_d      = !word_clean;
                    word_cnt_d = (word_cnt_q == CNT_MAX[CNT_W-1:0]) ? word_cnt_q
                                                                    : word_cnt_q + 1'b1;
                    err_cnt_d  = (err_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                                     : err_sum[CNT_W-1:0];
                    if (!word_clean) begin
                        if (bad_run_q == BRUN_W'(UNLOCK_CNT - 1)) begin
                            state_d     = HUNT;
                            clean_run_d = '0;
                            bad_run_d   = '0;
                        end else begin
                            bad_run_d = bad_run_q + 1'b1;
                        end
                    end else begin
                        bad_run_d = '0;
                    end
                end

                default: state_d = HUNT;
            endcase
        end

        // Clear wins over a word counted in the same cycle; lock state is untouched.
        if (clear_cnt_in) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end
    end

    // State register with synchronous, active-high reset.
    always_ff @(posedge gtwiz_userclk_rx_usrclk2_in) begin
        if (gtwiz_reset_all_in) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= HUNT;
            seed_q      <= '0;
            lfsr_q      <= '0;
            clean_run_q <= '0;
            bad_run_q   <= '0;
            err_q       <= 1'b0;
            err_bits_q  <= '0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            lfsr_q      <= lfsr_d;
            clean_run_q <= clean_run_d;
            bad_run_q   <= bad_run_d;
            err_q       <= err_d;
            err_bits_q  <= err_bits_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign locked_out   = (state_q == LOCKED);
    assign err_out      = err_q;
    assign err_bits_out = err_bits_q;
    assign err_cnt_out  = err_cnt_q;
    assign word_cnt_out = word_cnt_q;

endmodule

// File: tb/tb_prbs_chk.sv
// Bench for prbs_chk: PRBS7 transmit stream with directed and random impairments.
// Two instances share stimulus: default counters and 4-bit counters.
module tb_prbs_chk;

    localparam int LOCK   = 4;
    localparam int UNLOCK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_valid_in;
    logic        clear_cnt_in;

    logic        locked1, err1;
    logic [5:0]  bits1;
    logic [31:0] ecnt1, wcnt1;
    logic        locked2, err2;
    logic [5:0]  bits2;
    logic [3:0]  ecnt2, wcnt2;

    prbs_chk u_dut (
        .gtwiz_userclk_rx_usrclk2_in (clk),
        .gtwiz_reset_all_in          (rst),
        .data_in                     (data_in),
        .data_valid_in               (data_valid_in),
        .clear_cnt_in                (clear_cnt_in),
        .locked_out                  (locked1),
        .err_out                     (err1),
        .err_bits_out                (bits1),
        .err_cnt_out                 (ecnt1),
        .word_cnt_out                (wcnt1)
    );

    prbs_chk #(.CNT_W(4)) u_dut_narrow (
        .gtwiz_userclk_rx_usrclk2_in (clk),
        .gtwiz_reset_all_in          (rst),
        .data_in                     (data_in),
        .data_valid_in               (data_valid_in),
        .clear_cnt_in                (clear_cnt_in),
        .locked_out                  (locked2),
        .err_out                     (err2),
        .err_bits_out                (bits2),
        .err_cnt_out                 (ecnt2),
        .word_cnt_out                (wcnt2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PRBS7 (x^7+x^6+1) as a bit sequence: s[m] = s[m-6] ^ s[m-7].
    // hist[6] is the oldest of the previous 7 bits; the first new bit is the MSB.
    function automatic logic [31:0] gen_word(input logic [6:0] hist);
        bit s[39];
        logic [31:0] w;
        for (int j = 0; j < 7; j++) s[j] = hist[6-j];
        for (int m = 7; m < 39; m++) s[m] = s[m-6] ^ s[m-7];
        for (int i = 0; i < 32; i++) w[31-i] = s[7+i];
        return w;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Behavioural reference model, updated once per clock edge.
    bit          m_locked;
    logic [31:0] m_prev;
    logic [6:0]  m_hist;
    int          m_crun, m_brun;
    bit          m_err;
    int          m_bits;
    longint      m_etot, m_wtot;

    task automatic model_step(input logic [31:0] d, input bit v, input bit clr, input bit r);
        logic [31:0] pred;
        int          nerr;
        if (r) begin
            m_locked = 0; m_prev = '0; m_hist = '0; m_crun = 0; m_brun = 0;
            m_err = 0; m_bits = 0; m_etot = 0; m_wtot = 0;
            return;
        end
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                pred   = gen_word(m_prev[6:0]);
                m_bits = 0;
                if (m_prev[6:0] != 7'd0 && d == pred) begin
                    m_crun++;
                    if (m_crun == LOCK) begin
                        m_locked = 1; m_hist = d[6:0]; m_crun = 0; m_brun = 0;
                    end
                end else begin
                    m_crun = 0;
                end
            end else begin
                pred   = gen_word(m_hist);
                m_hist = pred[6:0];
                nerr   = $countones(d ^ pred);
                m_bits = nerr;
                m_err  = (nerr != 0);
                m_wtot++;
                m_etot += nerr;
                if (nerr != 0) begin
                    m_brun++;
                    if (m_brun == UNLOCK) begin
                        m_locked = 0; m_crun = 0; m_brun = 0;
                    end
                end else begin
                    m_brun = 0;
                end
            end
            m_prev = d;
        end
        if (clr) begin
            m_etot = 0; m_wtot = 0;
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",    locked1, m_locked);
            check("err",       err1,    m_err);
            check("err_bits",  bits1,   m_bits);
            check("err_cnt",   ecnt1,   sat(m_etot, 32));
            check("word_cnt",  wcnt1,   sat(m_wtot, 32));
            check("locked_n",  locked2, m_locked);
            check("err_n",     err2,    m_err);
            check("err_bits_n",bits2,   m_bits);
            check("err_cnt_n", ecnt2,   sat(m_etot, 4));
            check("word_cnt_n",wcnt2,   sat(m_wtot, 4));
        end
    end

    logic [6:0] tx_hist;

    task automatic step(input logic [31:0] d, input bit v, input bit clr, input bit r);
        data_in = d; data_valid_in = v; clear_cnt_in = clr; rst = r;
        @(posedge clk);
        model_step(d, v, clr, r);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] mask, input bit clr);
        logic [31:0] w;
        w       = gen_word(tx_hist);
        tx_hist = w[6:0];
        step(w ^ mask, 1'b1, clr, 1'b0);
    endtask

    initial begin
        int burst;
        int r;
        logic [31:0] mask;
        chk_en = 1'b1;
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);

        // Pin the stream model to hand-derived PRBS7 words from seed 7F.
        check("prbs7_w0", gen_word(7'h7F), 32'h020C28F2);
        check("prbs7_w1", gen_word(7'h72), 32'h2CEA7D0E);

        // Clean stream: seed word plus LOCK clean words.
        tx_hist = 7'h7F;
        step({25'd0, 7'h7F}, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= LOCK; i++) begin
            send_word('0, 1'b0);
            if (i == LOCK - 1) check("lock_early", locked1, 1'b0);
        end
        check("lock_at5", locked1, 1'b1);
        check("wcnt_lockword", wcnt1, 32'd0);
        for (int i = 0; i < 3; i++) send_word('0, 1'b0);
        check("wcnt_3", wcnt1, 32'd3);
        check("ecnt_clean", ecnt1, 32'd0);

        // Single bit flip: one pulse, no propagation.
        send_word(32'h1, 1'b0);
        check("flip_err", err1, 1'b1);
        check("flip_bits", bits1, 6'd1);
        check("flip_ecnt", ecnt1, 32'd1);
        send_word('0, 1'b0);
        check("flip_after_err", err1, 1'b0);
        check("flip_after_bits", bits1, 6'd0);
        check("flip_keep_lock", locked1, 1'b1);

        // Clear with a counted word.
        send_word('0, 1'b1);
        check("clr_ecnt", ecnt1, 32'd0);
        check("clr_wcnt", wcnt1, 32'd0);
        check("clr_lock", locked1, 1'b1);

        // Four errored words unlock; four clean words relock.
        for (int i = 1; i <= UNLOCK; i++) begin
            send_word(32'hE000_0000, 1'b0);
            check("burst_bits", bits1, 6'd3);
            if (i == UNLOCK - 1) check("burst_still_locked", locked1, 1'b1);
        end
        check("burst_unlock", locked1, 1'b0);
        check("burst_ecnt", ecnt1, 32'd12);
        for (int i = 1; i <= LOCK; i++) begin
            send_word('0, 1'b0);
            if (i == LOCK - 1) check("relock_early", locked1, 1'b0);
        end
        check("relock", locked1, 1'b1);
        check("relock_wcnt", wcnt1, 32'd4);

        // Saturation of the 4-bit counters.
        send_word('0, 1'b1);
        send_word(32'h0000_00FF, 1'b0);
        send_word('0, 1'b0);
        send_word(32'h0000_FF00, 1'b0);
        send_word('0, 1'b0);
        check("sat_ecnt_wide", ecnt1, 32'd16);
        check("sat_ecnt_narrow", ecnt2, 4'd15);
        for (int i = 0; i < 12; i++) send_word('0, 1'b0);
        check("sat_wcnt_wide", wcnt1, 32'd16);
        check("sat_wcnt_narrow", wcnt2, 4'd15);

        // All-zero input never locks.
        step('0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step('0, 1'b1, 1'b0, 1'b0);
        check("zero_nolock", locked1, 1'b0);

        // Valid toggling: lock timing counts valid words only.
        step('0, 1'b0, 1'b0, 1'b1);
        tx_hist = 7'h7F;
        step({25'd0, 7'h7F}, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= LOCK; i++) begin
            step($urandom, 1'b0, 1'b0, 1'b0);
            send_word('0, 1'b0);
            if (i == LOCK - 1) check("toggle_early", locked1, 1'b0);
        end
        check("toggle_lock", locked1, 1'b1);
        step($urandom, 1'b0, 1'b0, 1'b0);
        check("toggle_hold_lock", locked1, 1'b1);
        check("toggle_err_low", err1, 1'b0);

        // Reset pulse while locked, then relock after 1+LOCK valid words.
        step($urandom, 1'b1, 1'b0, 1'b1);
        check("rst_lock", locked1, 1'b0);
        check("rst_wcnt", wcnt1, 32'd0);
        check("rst_bits", bits1, 6'd0);
        for (int i = 1; i <= LOCK + 1; i++) begin
            send_word('0, 1'b0);
            if (i == LOCK) check("rst_relock_early", locked1, 1'b0);
        end
        check("rst_relock", locked1, 1'b1);

        // Randomised traffic against the model.
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                step($urandom, 1'b0, 1'b0, 1'b1);
            end else if (r < 4) begin
                tx_hist = 7'($urandom);
            end else if (r < 6) begin
                step('0, 1'b1, 1'b0, 1'b0);
            end else if (r < 50) begin
                step($urandom, 1'b0, 1'b0, 1'b0);
            end else begin
                mask = '0;
                if (burst > 0) begin
                    mask = $urandom | 32'h1;
                    burst--;
                end else if (r < 56) begin
                    mask = 32'h1 << $urandom_range(0, 31);
                end else if (r < 58) begin
                    mask = $urandom;
                end else if (r == 58) begin
                    burst = $urandom_range(3, 6);
                end
                send_word(mask, $urandom_range(0, 59) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_chk.md
Name: prbs_chk

Overview:
- Receive-side PRBS checker, the counterpart of the transmit-side PRBS generator. Sits on the transceiver RX user-clock domain and takes the parallel received word.
- Self-synchronises to the incoming PRBS stream, then free-runs its own LFSR.
- Reports lock status, per-word bit errors, and saturating error and word counters for link BER measurement.

Parameters:
- size, 32: data word width in bits; must be >= length.
- length, 7: LFSR length (PRBS order).
- primpoly, 7'b0000011: tap vector, declared [0:length-1]. primpoly[k-1]=1 means tap at delay k. The default gives taps 6,7, i.e. PRBS7, x^7+x^6+1.
- LOCK_CNT, 4: consecutive clean words in HUNT required to declare lock.
- UNLOCK_CNT, 4: consecutive errored words in LOCKED that force return to HUNT.
- CNT_W, 32: width of err_cnt_out and word_cnt_out.

Ports:
- gtwiz_userclk_rx_usrclk2_in  in  1  RX user clock; all logic on its rising edge.
- gtwiz_reset_all_in  in  1  synchronous, active-high reset.
- data_in  in  size  received word; data_in[size-1] is the earliest bit in time.
- data_valid_in  in  1  data_in qualifier; when low, all state and counters hold.
- clear_cnt_in  in  1  synchronous clear of err_cnt_out and word_cnt_out.
- locked_out  out  1  high in LOCKED state.
- err_out  out  1  one-cycle pulse: the last checked word had >=1 bit error while LOCKED.
- err_bits_out  out  clog2(size+1)  bit-error count of the last checked word; 0 when not LOCKED.
- err_cnt_out  out  CNT_W  saturating accumulated bit errors while LOCKED.
- word_cnt_out  out  CNT_W  saturating count of words checked while LOCKED.

Behaviour:
- Sequence definition: x[n] = XOR over k=1..length of (primpoly[k-1] & x[n-k]). Within a word, bits run from MSB (earliest) to LSB (latest).
- Prediction: given the last `length` bits of the previous word, the predicted word P is the next `size` sequence bits. This is purely combinational (unrolled LFSR).
- Reset: state=HUNT, all outputs 0, LFSR state 0, clean/bad run counters 0.
- Latency: outputs reflect the word presented on the previous valid cycle (1-cycle registered).

HUNT state:
- P is seeded from the previous received word's last `length` bits.
- A word is clean if data_in == P and the previous received word's seed bits are nonzero. An all-zero seed is never clean, because the all-zero stream is not a PRBS.
- Clean word: clean_run++. Otherwise clean_run = 0.
- When clean_run reaches LOCK_CNT: go to LOCKED and load the LFSR state from the last `length` bits of data_in.
- The first valid word after reset has no previous word; it only loads the seed and is never clean.
- err_out=0, err_bits_out=0 and counters are not updated in HUNT.

LOCKED state:
- P is generated from the internal LFSR state, not from received data, so a single bit error counts once. The LFSR advances by `size` bits per valid word.
- err_bits = popcount(data_in ^ P). err_out = (err_bits != 0).
- word_cnt += 1 and err_cnt += err_bits, each saturating at 2^CNT_W-1.
- Errored word: bad_run++. Clean word: bad_run = 0.
- When bad_run reaches UNLOCK_CNT: go to HUNT, clear clean_run, locked_out=0 from the next cycle. The word that triggers unlock is still counted.

Simultaneous events and clears:
- clear_cnt_in together with a counted word: clear wins; the counters read 0 and that word is discarded from the totals.
- clear_cnt_in does not affect lock state.
- gtwiz_reset_all_in mid-operation: same as the reset values above on the next edge, with priority over everything.
- data_valid_in=0: no state change. err_out deasserts; err_bits_out holds its last value.

Test Plan:
- Clean PRBS7, size=32, seed 7'h7F, continuous valid -> locked_out rises after exactly 1+LOCK_CNT=5 valid words (plus 1-cycle latency); err_cnt_out stays 0; word_cnt_out increments by 1 per word.
- Once locked, flip bit 0 of one word -> exactly one err_out pulse with err_bits_out=1; err_cnt_out=1; lock is kept; the following words are clean (no error propagation).
- Once locked, flip 3 bits in each of 4 consecutive words -> err_cnt_out=12; locked_out falls after the 4th; re-lock after 4 further clean words.
- All-zero data_in for 20 words -> locked_out stays 0.
- Counter and reset controls:
  - Hold 1s on err_bits with CNT_W=4 -> err_cnt_out saturates at 15.
  - clear_cnt_in asserted while locked -> both counters are 0 next cycle and locked_out stays 1.
- Toggle data_valid_in 1/0 on a clean stream -> lock timing counts valid words only; gtwiz_reset_all_in pulse while locked -> all outputs 0 next cycle, then re-lock after 5 valid words.
